// File: rtl/player_position_stepper.sv
// Head-position stepper for one player: moves the head one cell every TICK_DIV cycles,
// handshakes each new head with the plotter, and ends the round on a hit or an edge step (`WRAP_EN wraps instead).
module player_position_stepper #(
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int X_INIT   = 80,
  parameter int Y_INIT   = 60,
  parameter int TICK_DIV = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] direction,
  input  logic       head_ready,
  input  logic       hit,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       head_valid,
  output logic       crashed
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]    X_MAX     = 8'(GRID_W - 1);
  localparam logic [6:0]    Y_MAX     = 7'(GRID_H - 1);
  localparam logic [7:0]    X_RST     = 8'(X_INIT);
  localparam logic [6:0]    Y_RST     = 7'(Y_INIT);

`ifdef WRAP_EN
  localparam bit EDGE_CRASH = 1'b0;
`else
  localparam bit EDGE_CRASH = 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_PLOT = 2'd2,
    CRASH     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  state_t        r_state, w_state_n;
  logic [TW-1:0] r_tick,  w_tick_n;
  logic [7:0]    r_x,     w_x_n;
  logic [6:0]    r_y,     w_y_n;
  logic          r_head_valid, w_head_valid_n;
  logic          r_crashed,    w_crashed_n;

  logic [7:0]    w_step_x;
  logic [6:0]    w_step_y;
  logic          w_at_edge;

  // Candidate next cell; at an edge the candidate is the wrapped cell, used only when wrapping is built in.
  always_comb begin
    w_step_x  = r_x;
    w_step_y  = r_y;
    w_at_edge = 1'b0;
    unique case (dir_t'(direction))
      DIR_UP: begin
        w_at_edge = (r_y == 7'd0);
        w_step_y  = w_at_edge ? Y_MAX : r_y - 7'd1;
      end
      DIR_RIGHT: begin
        w_at_edge = (r_x == X_MAX);
        w_step_x  = w_at_edge ? 8'd0 : r_x + 8'd1;
      end
      DIR_DOWN: begin
        w_at_edge = (r_y == Y_MAX);
        w_step_y  = w_at_edge ? 7'd0 : r_y + 7'd1;
      end
      DIR_LEFT: begin
        w_at_edge = (r_x == 8'd0);
        w_step_x  = w_at_edge ? X_MAX : r_x - 8'd1;
      end
    endcase
  end

  // NOTE: every signal written here is given a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_n      = r_state;
    w_tick_n       = r_tick;
    w_x_n          = r_x;
    w_y_n          = r_y;
    w_head_valid_n = r_head_valid;
    w_crashed_n    = r_crashed;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n = RUN;
          w_tick_n  = '0;
        end
      end
      RUN: begin
        if (r_tick == TICK_LAST) begin
          w_tick_n = '0;
          if (EDGE_CRASH && w_at_edge) begin
            w_crashed_n = 1'b1;
            w_state_n   = CRASH;
          end else begin
            w_x_n          = w_step_x;
            w_y_n          = w_step_y;
            w_head_valid_n = 1'b1;
            w_state_n      = WAIT_PLOT;
          end
        end else begin
          w_tick_n = r_tick + TW'(1);
        end
      end
      WAIT_PLOT: begin
        // Tick counter is frozen here so no step can overtake an unplotted head.
        if (r_head_valid && head_ready) begin
          w_head_valid_n = 1'b0;
          if (hit) begin
            w_crashed_n = 1'b1;
            w_state_n   = CRASH;
          end else begin
            w_state_n = RUN;
          end
        end
      end
      CRASH: begin
        if (start) begin
          w_x_n       = X_RST;
          w_y_n       = Y_RST;
          w_crashed_n = 1'b0;
          w_state_n   = IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_tick       <= '0;
      r_x          <= X_RST;
      r_y          <= Y_RST;
      r_head_valid <= 1'b0;
      r_crashed    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_tick       <= w_tick_n;
      r_x          <= w_x_n;
      r_y          <= w_y_n;
      r_head_valid <= w_head_valid_n;
      r_crashed    <= w_crashed_n;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign head_valid = r_head_valid;
  assign crashed    = r_crashed;

endmodule

// File: tb/tb_player_position_stepper.sv
// Directed bench for player_position_stepper with TICK_DIV=4 on a 160x120 grid; a second
// instance starts at x=0 to exercise the left edge in both WRAP_EN builds.
module tb_player_position_stepper;

  logic       CLOCK_50 = 1'b0;
  logic       resetn, start, head_ready, hit;
  logic [1:0] direction;
  logic [7:0] x;
  logic [6:0] y;
  logic       head_valid, crashed;

  logic       e_resetn, e_start, e_head_ready, e_hit;
  logic [1:0] e_direction;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic       e_head_valid, e_crashed;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  player_position_stepper #(
    .GRID_W(160), .GRID_H(120), .X_INIT(80), .Y_INIT(60), .TICK_DIV(4)
  ) u_dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .direction(direction),
    .head_ready(head_ready), .hit(hit), .x(x), .y(y),
    .head_valid(head_valid), .crashed(crashed)
  );

  player_position_stepper #(
    .GRID_W(160), .GRID_H(120), .X_INIT(0), .Y_INIT(60), .TICK_DIV(4)
  ) u_dut_edge (
    .CLOCK_50(CLOCK_50), .resetn(e_resetn), .start(e_start), .direction(e_direction),
    .head_ready(e_head_ready), .hit(e_hit), .x(e_x), .y(e_y),
    .head_valid(e_head_valid), .crashed(e_crashed)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  task automatic run_cadence(input bit hold_start);
    bit exp_hv;
    do_reset();
    direction  = 2'b01;
    head_ready = 1'b1;
    hit        = 1'b0;
    start      = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_hv = ((k % 5) == 4);
      check($sformatf("cad%0d_hv_k%0d", hold_start, k), 32'(head_valid), 32'(exp_hv));
      if (exp_hv) begin
        check($sformatf("cad%0d_x_k%0d", hold_start, k), 32'(x), 32'(80 + k / 5 + 1));
        check($sformatf("cad%0d_y_k%0d", hold_start, k), 32'(y), 32'd60);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; direction = 2'b01; head_ready = 1'b1; hit = 1'b0;
    e_resetn = 1'b0; e_start = 1'b0; e_direction = 2'b10; e_head_ready = 1'b1; e_hit = 1'b0;
    #12;
    check("rst_x",       32'(x),          32'd80);
    check("rst_y",       32'(y),          32'd60);
    check("rst_hv",      32'(head_valid), 32'd0);
    check("rst_crashed", 32'(crashed),    32'd0);
    check("rst_e_x",     32'(e_x),        32'd0);
    resetn   = 1'b1;
    e_resetn = 1'b1;
    tick();

    // Steady rightward travel with a start pulse, then with start held through RUN.
    run_cadence(1'b0);
    run_cadence(1'b1);

    // Head held unacknowledged, then accepted as a hit.
    do_reset();
    direction  = 2'b00;
    head_ready = 1'b0;
    hit        = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("stall_first_hv", 32'(head_valid), 32'd1);
    check("stall_first_y",  32'(y),          32'd59);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("stall_hv_%0d", i), 32'(head_valid), 32'd1);
      check($sformatf("stall_x_%0d", i),  32'(x),          32'd80);
      check($sformatf("stall_y_%0d", i),  32'(y),          32'd59);
    end
    head_ready = 1'b1;
    hit        = 1'b1;
    tick();
    check("hit_hv",      32'(head_valid), 32'd0);
    check("hit_crashed", 32'(crashed),    32'd1);
    direction = 2'b11;
    for (int i = 0; i < 12; i++) begin
      head_ready = i[0];
      hit        = i[1];
      tick();
      check($sformatf("crash_x_%0d", i),  32'(x),          32'd80);
      check($sformatf("crash_y_%0d", i),  32'(y),          32'd59);
      check($sformatf("crash_hv_%0d", i), 32'(head_valid), 32'd0);
    end
    head_ready = 1'b0;
    hit        = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("restart_x",       32'(x),             32'd80);
    check("restart_y",       32'(y),             32'd60);
    check("restart_crashed", 32'(crashed),       32'd0);
    check("restart_state",   32'(u_dut.r_state), 32'd0);
    tick();
    check("idle_hold_state", 32'(u_dut.r_state), 32'd0);
    check("idle_hold_hv",    32'(head_valid),    32'd0);

    // Asynchronous reset in the middle of a pending handshake.
    do_reset();
    direction  = 2'b01;
    head_ready = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_arst_hv", 32'(head_valid), 32'd1);
    check("pre_arst_x",  32'(x),          32'd81);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_hv",      32'(head_valid), 32'd0);
    check("arst_x",       32'(x),          32'd80);
    check("arst_y",       32'(y),          32'd60);
    check("arst_crashed", 32'(crashed),    32'd0);
    resetn = 1'b1;
    tick();

    // Left edge step from x=0.
    e_start = 1'b1;
    tick();
    e_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("edge_pre_hv_%0d", i), 32'(e_head_valid), 32'd0);
    end
    tick();
`ifdef WRAP_EN
    check("edge_hv",      32'(e_head_valid), 32'd1);
    check("edge_x",       32'(e_x),          32'd159);
    check("edge_y",       32'(e_y),          32'd60);
    check("edge_crashed", 32'(e_crashed),    32'd0);
    tick();
    check("edge_ack_hv", 32'(e_head_valid), 32'd0);
    check("edge_ack_x",  32'(e_x),          32'd159);
`else
    check("edge_hv",      32'(e_head_valid), 32'd0);
    check("edge_x",       32'(e_x),          32'd0);
    check("edge_y",       32'(e_y),          32'd60);
    check("edge_crashed", 32'(e_crashed),    32'd1);
    repeat (5) tick();
    check("edge_late_hv",      32'(e_head_valid), 32'd0);
    check("edge_late_x",       32'(e_x),          32'd0);
    check("edge_late_crashed", 32'(e_crashed),    32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/player_position_stepper.md
PLAYER_POSITION_STEPPER -- requirements
Module: player_position_stepper

Interface
REQ-001 The block SHALL have parameter GRID_W, default 160, meaning grid width in cells.
REQ-002 The block SHALL have parameter GRID_H, default 120, meaning grid height in cells.
REQ-003 The block SHALL have parameters X_INIT/Y_INIT, defaults 80/60, meaning the head position loaded at reset and restart.
REQ-004 The block SHALL have parameter TICK_DIV, default 2500000, meaning CLOCK_50 cycles per movement step.
REQ-005 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: begin or restart the round.
REQ-008 The block SHALL have port direction, input, 2 bits: filtered heading from the direction register (00 up, 01 right, 11 down, 10 left).
REQ-009 The block SHALL have port head_ready, input, 1 bit: downstream plotter accepts the head.
REQ-010 The block SHALL have port hit, input, 1 bit: plotter flags the cell as already occupied; qualified by head_valid&&head_ready.
REQ-011 The block SHALL have ports x (8 bits) and y (7 bits), outputs: current head cell.
REQ-012 The block SHALL have port head_valid, output, 1 bit: x/y hold a new, unplotted head.
REQ-013 The block SHALL have port crashed, output, 1 bit: the round has ended for this player.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, WAIT_PLOT, CRASH.
REQ-015 In IDLE, start=1 SHALL move to RUN with the tick counter at 0.
REQ-016 In RUN, the tick counter SHALL increment each cycle; on reaching TICK_DIV-1 it SHALL clear to 0.
REQ-017 On that same cycle, the block SHALL sample direction, compute the next cell, and update x/y on the following edge with head_valid=1 and state=WAIT_PLOT (step latency: 1 cycle after terminal count).
REQ-018 Direction updates SHALL apply as follows: 00 sets y-1, 01 sets x+1, 11 sets y+1, and 10 sets x-1; the other coordinate SHALL be unchanged.
REQ-019 The tick counter SHALL be held in WAIT_PLOT; there SHALL be no step while the head is unacknowledged.
REQ-020 In WAIT_PLOT, head_valid, x and y SHALL stay stable until head_ready=1.
REQ-021 On head_valid&&head_ready with hit=0, the block SHALL drop head_valid and return to RUN on the next cycle.
REQ-022 On head_valid&&head_ready with hit=1, the block SHALL drop head_valid, set crashed=1, and move to CRASH.
REQ-023 An edge step (x=0 with left, x=GRID_W-1 with right, y=0 with up, y=GRID_H-1 with down) SHALL be handled per REQ-029/030.
REQ-024 In CRASH, x/y SHALL be frozen and direction, head_ready and hit SHALL be ignored; start=1 SHALL reload X_INIT/Y_INIT, clear crashed, and move to IDLE.
REQ-025 start SHALL be ignored in RUN and WAIT_PLOT.
REQ-026 Coordinate arithmetic SHALL be unsigned, at 8-bit width for x and 7-bit width for y; no intermediate wrap outside REQ-029 SHALL be permitted.

Reset
REQ-027 On resetn=0, asynchronously and regardless of state (including mid-step or mid-handshake), the block SHALL set state=IDLE, x=X_INIT, y=Y_INIT, head_valid=0, crashed=0, and tick counter=0.
REQ-028 After reset release, the first movement SHALL occur no earlier than TICK_DIV cycles after start is accepted.

Configuration
REQ-029 With WRAP_EN defined, an edge step SHALL wrap to the opposite edge (x 0 to GRID_W-1 and vice versa; same for y) and proceed to WAIT_PLOT normally.
REQ-030 Without WRAP_EN, an edge step SHALL leave x/y unchanged, keep head_valid=0, set crashed=1, and move to CRASH on the edge after terminal count.

Verification (TICK_DIV=4, 160x120 grid, init 80/60)
REQ-031 The bench SHALL cover this case: reset, start pulse, direction=01, head_ready=1, hit=0 -> head_valid pulses every 5 cycles with x=81, 82, 83 and y=60.
REQ-032 The bench SHALL cover this case: direction=00, head_ready held 0 for 10 cycles -> x/y=80/59 stable, head_valid=1 throughout, no further step.
REQ-033 The bench SHALL cover this case: first step accepted with hit=1 -> crashed=1 the next cycle; later ticks leave x/y=80/59; start then gives x/y=80/60, crashed=0, IDLE.
REQ-034 The bench SHALL cover this case: X_INIT=0, direction=10 -> without WRAP_EN, crashed=1, x=0, no head_valid; with WRAP_EN, head_valid with x=159.
REQ-035 The bench SHALL cover this case: resetn=0 asserted while head_valid=1 in WAIT_PLOT -> head_valid=0, x/y=80/60, crashed=0 immediately, without waiting for a clock edge.
REQ-036 The bench SHALL cover this case: start held high through RUN -> no restart and no change in step cadence.
